// File: rtl/sync_fifo_pkg.sv
// Shared types and sizing helpers for the programmable synchronous FIFO.
//   clog2  : ceiling log2 for sizing address fields
//   cnt_w  : pointer/count width for a given depth (address width + 1)
//   fifo_flags_t : registered status flag vector
package sync_fifo_pkg;

  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin end
    return r;
  endfunction

  // One extra bit so a full FIFO (count == DEPTH) is representable
  // and pointers can distinguish full from empty.
  function automatic int cnt_w(input int depth);
    return clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic almost_full;
    logic almost_empty;
    logic full;
    logic empty;
  } fifo_flags_t;

  localparam fifo_flags_t FLAGS_RST = '{
    overflow: 1'b0, underflow: 1'b0, almost_full: 1'b0,
    almost_empty: 1'b1, full: 1'b0, empty: 1'b1
  };

endpackage

// File: rtl/sync_fifo_prog_if.sv
// Producer/consumer bundle for sync_fifo_prog.
//   master : drives write/read requests, thresholds, error clear
//   slave  : the FIFO; returns read data, occupancy and status flags
interface sync_fifo_prog_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
);
  import sync_fifo_pkg::*;
  localparam int CW = cnt_w(DEPTH);

  logic             i_we;
  logic [WIDTH-1:0] i_wdata;
  logic             i_re;
  logic [CW-1:0]    i_af_level;
  logic [CW-1:0]    i_ae_level;
  logic             i_clr_err;
  logic [WIDTH-1:0] o_rdata;
  logic             o_rvalid;
  logic             o_full;
  logic             o_empty;
  logic             o_almost_full;
  logic             o_almost_empty;
  logic [CW-1:0]    o_count;
  logic             o_overflow;
  logic             o_underflow;

  modport master (
    output i_we, i_wdata, i_re, i_af_level, i_ae_level, i_clr_err,
    input  o_rdata, o_rvalid, o_full, o_empty, o_almost_full, o_almost_empty,
           o_count, o_overflow, o_underflow
  );

  modport slave (
    input  i_we, i_wdata, i_re, i_af_level, i_ae_level, i_clr_err,
    output o_rdata, o_rvalid, o_full, o_empty, o_almost_full, o_almost_empty,
           o_count, o_overflow, o_underflow
  );
endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH storage for sync_fifo_prog.
//   clk/we/waddr/wdata : synchronous write port
//   raddr/rdata        : asynchronous read port
// Contents are not reset.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with occupancy count, runtime almost-full/almost-empty
// thresholds and sticky overflow/underflow flags.
//   i_clk, i_resetn : clock, async active-low reset (sync release expected)
//   bus (slave)     : write/read requests, thresholds, error clear, read data,
//                     count and status flags
// Build option SYNC_FIFO_FWFT_EN: first-word-fall-through read (head word shown
// combinationally, i_re acknowledges it). Default: registered read, 1-cycle latency.
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic            i_clk,
  input  logic            i_resetn,
  sync_fifo_prog_if.slave bus
);
  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wptr, rptr, count, count_nxt;
  fifo_flags_t      flags, flags_nxt;
  logic             wr_ok, rd_ok;
  logic [WIDTH-1:0] mem_rd;

  // Acceptance uses the registered flags of the current cycle.
  assign wr_ok = bus.i_we & ~flags.full;
  assign rd_ok = bus.i_re & ~flags.empty;

  always_comb begin
    count_nxt = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + PW'(1);
      2'b01:   count_nxt = count - PW'(1);
      default: count_nxt = count;
    endcase
    flags_nxt.full         = (count_nxt == PW'(DEPTH));
    flags_nxt.empty        = (count_nxt == '0);
    flags_nxt.almost_full  = (count_nxt >= bus.i_af_level);
    flags_nxt.almost_empty = (count_nxt <= bus.i_ae_level);
    // A fresh error outranks a clear in the same cycle.
    flags_nxt.overflow     = (bus.i_we & flags.full)  | (flags.overflow  & ~bus.i_clr_err);
    flags_nxt.underflow    = (bus.i_re & flags.empty) | (flags.underflow & ~bus.i_clr_err);
  end

  always_ff @(posedge i_clk or negedge i_resetn)
    if (!i_resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      flags <= FLAGS_RST;
    end else begin
      if (wr_ok) wptr <= wptr + PW'(1);
      if (rd_ok) rptr <= rptr + PW'(1);
      count <= count_nxt;
      flags <= flags_nxt;
    end

  sync_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk   (i_clk),
    .we    (wr_ok),
    .waddr (wptr[AW-1:0]),
    .wdata (bus.i_wdata),
    .raddr (rptr[AW-1:0]),
    .rdata (mem_rd)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is always on the output; i_re just advances rptr.
  assign bus.o_rdata  = mem_rd;
  assign bus.o_rvalid = ~flags.empty;
`else
  logic [WIDTH-1:0] rdata_q;
  logic             rvalid_q;

  // rdata holds the last word read; rvalid pulses for one cycle per read.
  always_ff @(posedge i_clk or negedge i_resetn)
    if (!i_resetn) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      if (rd_ok) rdata_q <= mem_rd;
      rvalid_q <= rd_ok;
    end

  assign bus.o_rdata  = rdata_q;
  assign bus.o_rvalid = rvalid_q;
`endif

  assign bus.o_count        = count;
  assign bus.o_full         = flags.full;
  assign bus.o_empty        = flags.empty;
  assign bus.o_almost_full  = flags.almost_full;
  assign bus.o_almost_empty = flags.almost_empty;
  assign bus.o_overflow     = flags.overflow;
  assign bus.o_underflow    = flags.underflow;
endmodule

// File: tb/tb_sync_fifo_prog.sv
// Self-checking bench for sync_fifo_prog: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_sync_fifo_prog;
  localparam int WIDTH = 8;
  localparam int DEPTH = 32;
  localparam int CW    = 6;

  logic i_clk    = 1'b0;
  logic i_resetn = 1'b1;
  always #5 i_clk = ~i_clk;

  sync_fifo_prog_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  sync_fifo_prog #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .bus      (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [WIDTH-1:0] q[$];
  bit               m_af, m_ae, m_ovf, m_udf, m_rv;
  logic [WIDTH-1:0] m_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("count",        32'(bus.o_count),        32'(q.size()));
    chk("full",         32'(bus.o_full),         32'(q.size() == DEPTH));
    chk("empty",        32'(bus.o_empty),        32'(q.size() == 0));
    chk("almost_full",  32'(bus.o_almost_full),  32'(m_af));
    chk("almost_empty", 32'(bus.o_almost_empty), 32'(m_ae));
    chk("overflow",     32'(bus.o_overflow),     32'(m_ovf));
    chk("underflow",    32'(bus.o_underflow),    32'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
    chk("rvalid", 32'(bus.o_rvalid), 32'(q.size() != 0));
    if (q.size() != 0) chk("rdata", 32'(bus.o_rdata), 32'(q[0]));
`else
    chk("rvalid", 32'(bus.o_rvalid), 32'(m_rv));
    chk("rdata",  32'(bus.o_rdata),  32'(m_rd));
`endif
  endtask

  // One clock: present inputs, advance the model at the edge, check #1 later.
  task automatic step(input bit we, input logic [WIDTH-1:0] wd, input bit re, input bit clr);
    bit wr_ok, rd_ok;
    int af, ae;
    bus.i_we      = we;
    bus.i_wdata   = wd;
    bus.i_re      = re;
    bus.i_clr_err = clr;
    @(posedge i_clk);
    af    = int'(bus.i_af_level);
    ae    = int'(bus.i_ae_level);
    wr_ok = we && (q.size() < DEPTH);
    rd_ok = re && (q.size() > 0);
    m_ovf = (we && q.size() == DEPTH) || (m_ovf && !clr);
    m_udf = (re && q.size() == 0)     || (m_udf && !clr);
    m_rv  = rd_ok;
    if (rd_ok) m_rd = q.pop_front();
    if (wr_ok) q.push_back(wd);
    m_af = (q.size() >= af);
    m_ae = (q.size() <= ae);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    bus.i_we      = 1'b0;
    bus.i_re      = 1'b0;
    bus.i_clr_err = 1'b0;
    i_resetn      = 1'b0;
    #2;
    q.delete();
    m_af  = 1'b0;
    m_ae  = 1'b1;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_rv  = 1'b0;
    m_rd  = '0;
    check_outputs();
    @(negedge i_clk);
    i_resetn = 1'b1;
  endtask

  initial begin
    int wbias, rbias;
    bus.i_we       = 1'b0;
    bus.i_wdata    = '0;
    bus.i_re       = 1'b0;
    bus.i_clr_err  = 1'b0;
    bus.i_af_level = CW'(28);
    bus.i_ae_level = CW'(4);
    #1;
    do_reset();

    // Basic in-order transfer
    for (int i = 0; i < 16; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Fill past full, then drain past empty, then clear errors
    for (int i = 0; i < 33; i++) step(1'b1, WIDTH'(i + 40), 1'b0, 1'b0);
    for (int i = 0; i < 33; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);

    // Simultaneous read/write on a half-full FIFO across pointer wrap
    for (int i = 0; i < 16; i++) step(1'b1, WIDTH'(i + 200), 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) step(1'b1, WIDTH'(i), 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Simultaneous request on empty: write wins, underflow flagged
    step(1'b1, 8'h5a, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);

    // Reset mid-operation discards contents
    for (int i = 0; i < 16; i++) step(1'b1, WIDTH'(i + 1), 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, WIDTH'(100 + i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Single word into empty, then one read
    step(1'b1, 8'ha5, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    // Random traffic with drifting bias and changing thresholds
    wbias = 50;
    rbias = 50;
    for (int c = 0; c < 2000; c++) begin
      if (c % 150 == 0) begin
        wbias = $urandom_range(10, 90);
        rbias = $urandom_range(10, 90);
      end
      if (c % 97 == 0) begin
        bus.i_af_level = CW'($urandom_range(0, DEPTH));
        bus.i_ae_level = CW'($urandom_range(0, DEPTH));
      end
      if (c == 1234) do_reset();
      step($urandom_range(0, 99) < wbias, WIDTH'($urandom),
           $urandom_range(0, 99) < rbias, $urandom_range(0, 99) < 4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
